capture_buffer: RTL and testbench
=================================

Name: capture_buffer

Overview:
- Parametrised capture-then-forward sample buffer between the ADC read block and the Arduino write block.
- Captures a runtime-selectable number of SAMPLE_W-bit samples into an internal array.
- Then forwards them to the serial writer oldest-first, one sample per handshake.
- Adds start/done control, one-shot vs continuous modes, and a status readout.

Parameters:
- SAMPLE_W, 12: sample width in bits.
- DEPTH, 100: maximum number of samples stored.
- ADDR_W, 7: counter/pointer width; must satisfy 2^ADDR_W > DEPTH.
- CONTINUOUS, 0: 0 = one-shot per start request; 1 = re-arm automatically while start is held high.

Ports:
- clk  in  1  system clock (50 MHz); all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  request a capture/transmit cycle; level-sampled in IDLE.
- depth_sel  in  ADDR_W  number of samples per cycle; latched on leaving IDLE.
- adc_en  out  1  enable to the ADC read block.
- adc_valid  in  1  one-cycle pulse; adc_data is valid in that cycle.
- adc_data  in  SAMPLE_W  sample from the ADC read block.
- tx_en  out  1  enable to the Arduino write block.
- tx_data  out  SAMPLE_W  sample being transmitted.
- tx_done  in  1  one-cycle pulse; the writer has finished the current sample.
- busy  out  1  high in CAPTURE or TRANSMIT.
- done  out  1  one-cycle pulse at the end of a cycle.
- state  out  2  IDLE=0, CAPTURE=1, TRANSMIT=2, DONE=3.
- sample_cnt  out  ADDR_W  samples captured (CAPTURE) or sent (TRANSMIT).

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE; adc_en, tx_en, busy, done all 0; tx_data=0; sample_cnt=0; write/read pointers=0.
  - Array contents are not cleared and are don't-care.
  - Reset mid-capture or mid-transmit aborts immediately; the partial buffer is discarded.
- Limit latch: limit = depth_sel, except depth_sel==0 or depth_sel>DEPTH clamps to DEPTH.
- IDLE:
  - All outputs idle.
  - start==1 → CAPTURE next cycle; limit is latched and both pointers are cleared.
- CAPTURE:
  - adc_en=1 from the first CAPTURE cycle.
  - On adc_valid with adc_en==1: mem[wr]=adc_data, wr++, sample_cnt++.
  - adc_en drops to 0 for exactly one cycle after each accepted sample so the reader restarts its conversion, then returns to 1.
  - adc_valid while adc_en==0, or in any other state, is ignored.
  - When the accepted sample makes the count equal limit: adc_en=0 and the next state is TRANSMIT. sample_cnt resets to 0 on entry to TRANSMIT.
- TRANSMIT:
  - tx_data is registered from mem[rd] one cycle before tx_en rises, and is held stable while tx_en==1.
  - On tx_done with tx_en==1: tx_en=0 for one cycle, rd++, sample_cnt++.
  - After the final sample (sample_cnt==limit) go to DONE; tx_en stays 0.
  - Order is FIFO: the first sample captured is the first transmitted.
  - tx_done outside TRANSMIT is ignored.
- DONE:
  - done=1 for one cycle; busy=0.
  - Next state is CAPTURE if CONTINUOUS==1 and start==1 (limit re-latched, pointers cleared); otherwise IDLE.
- Simultaneous adc_valid and tx_done: only the one belonging to the current state is honoured.
- Pointers never wrap: capture stops at limit ≤ DEPTH.
- busy = (state==CAPTURE or state==TRANSMIT).
- All outputs are registered.

Test Plan:
- Reset then start=1, depth_sel=3, ADC returns 0x111, 0x222, 0x333 → adc_en has a one-cycle gap after each valid; tx_data sequence is 0x111, 0x222, 0x333, one per tx_done; done pulses once; state returns to 0.
- depth_sel=0 with DEPTH=100, ADC returns incrementing data 0..99 → exactly 100 samples captured and 100 transmitted in order 0..99; sample_cnt peaks at 100.
- adc_valid pulsed during the adc_en gap cycle and in IDLE, plus tx_done pulsed during CAPTURE → no pointer or count change; transmitted data is unaffected.
- rst=0 asserted for one cycle after 2 of 5 samples are transmitted → all outputs 0 and state=IDLE on the next cycle; a new start captures fresh data with no stale samples sent.
- CONTINUOUS=1, start held high, depth_sel=2 → done pulses, then CAPTURE is re-entered on the next cycle; two full cycles complete; dropping start before the second DONE → IDLE.
- depth_sel=127 (above DEPTH) → clamps to 100 samples; state never exceeds the DEPTH address.

Source files
------------

// File: rtl/capture_buffer.sv
// Capture-then-forward sample buffer between the ADC reader and the serial writer.
// Fills up to DEPTH samples, then replays them oldest-first, one per writer handshake.
module capture_buffer #(
    parameter int SAMPLE_W   = 12,
    parameter int DEPTH      = 100,
    parameter int ADDR_W     = 7,
    parameter int CONTINUOUS = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   depth_sel,
    output logic                adc_en,
    input  logic                adc_valid,
    input  logic [SAMPLE_W-1:0] adc_data,
    output logic                tx_en,
    output logic [SAMPLE_W-1:0] tx_data,
    input  logic                tx_done,
    output logic                busy,
    output logic                done,
    output logic [1:0]          state,
    output logic [ADDR_W-1:0]   sample_cnt
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CAPTURE  = 2'd1,
        S_TRANSMIT = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] ZERO_A  = '0;
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   limit_q, limit_d;
    logic [ADDR_W-1:0]   wr_q, wr_d;
    logic [ADDR_W-1:0]   rd_q, rd_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                adc_en_q, adc_en_d;
    logic                tx_en_q, tx_en_d;
    logic [SAMPLE_W-1:0] tx_data_q, tx_data_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                mem_we;
    logic [ADDR_W-1:0]   cnt_inc;
    logic [ADDR_W-1:0]   rd_inc;

    logic [SAMPLE_W-1:0] mem [DEPTH];

    // Zero or oversized requests fall back to the full buffer so pointers never wrap.
    function automatic logic [ADDR_W-1:0] clamp_limit(input logic [ADDR_W-1:0] sel);
        if (sel == ZERO_A || int'(sel) > DEPTH) begin
            return DEPTH_A;
        end
        return sel;
    endfunction

    assign cnt_inc = cnt_q + ONE_A;
    assign rd_inc  = rd_q + ONE_A;

    always_comb begin
        state_d   = state_q;
        limit_d   = limit_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        adc_en_d  = adc_en_q;
        tx_en_d   = tx_en_q;
        tx_data_d = tx_data_q;
        mem_we    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                adc_en_d  = 1'b0;
                tx_en_d   = 1'b0;
                tx_data_d = '0;
                cnt_d     = '0;
                if (start) begin
                    state_d  = S_CAPTURE;
                    limit_d  = clamp_limit(depth_sel);
                    wr_d     = '0;
                    rd_d     = '0;
                    adc_en_d = 1'b1;
                end
            end

            S_CAPTURE: begin
                tx_en_d = 1'b0;
                if (!adc_en_q) begin
                    adc_en_d = 1'b1;
                end else if (adc_valid) begin
                    // Drop enable for one cycle so the reader restarts its conversion.
                    mem_we   = 1'b1;
                    wr_d     = wr_q + ONE_A;
                    adc_en_d = 1'b0;
                    if (cnt_inc == limit_q) begin
                        state_d   = S_TRANSMIT;
                        cnt_d     = '0;
                        // With a one-sample cycle, the first sample is still in flight.
                        tx_data_d = (wr_q == ZERO_A) ? adc_data : mem[ZERO_A];
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            S_TRANSMIT: begin
                adc_en_d = 1'b0;
                if (!tx_en_q) begin
                    tx_en_d = 1'b1;
                end else if (tx_done) begin
                    tx_en_d = 1'b0;
                    rd_d    = rd_inc;
                    cnt_d   = cnt_inc;
                    if (cnt_inc == limit_q) begin
                        state_d = S_DONE;
                    end else begin
                        // Next sample settles during the gap, ahead of tx_en rising.
                        tx_data_d = mem[rd_inc];
                    end
                end
            end

            S_DONE: begin
                adc_en_d = 1'b0;
                tx_en_d  = 1'b0;
                if (CONTINUOUS != 0 && start) begin
                    state_d  = S_CAPTURE;
                    limit_d  = clamp_limit(depth_sel);
                    wr_d     = '0;
                    rd_d     = '0;
                    cnt_d    = '0;
                    adc_en_d = 1'b1;
                end else begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    tx_data_d = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        done_d = (state_d == S_DONE);
        busy_d = (state_d == S_CAPTURE) || (state_d == S_TRANSMIT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            limit_q   <= DEPTH_A;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            adc_en_q  <= 1'b0;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            limit_q   <= limit_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            adc_en_q  <= adc_en_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    // Sample storage carries no reset; stale contents are never read back.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_q] <= adc_data;
        end
    end

    assign adc_en     = adc_en_q;
    assign tx_en      = tx_en_q;
    assign tx_data    = tx_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign state      = state_q;
    assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_capture_buffer.sv
// Self-checking bench for capture_buffer: clamp table, random runs against a queue model,
// injected stray handshakes, mid-transmit reset and continuous re-arm.
module tb_capture_buffer;

    localparam int SW    = 12;
    localparam int DEPTH = 100;
    localparam int AW    = 7;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic          rst;
    logic          start, adc_valid, tx_done;
    logic [AW-1:0] depth_sel;
    logic [SW-1:0] adc_data;
    logic          adc_en, tx_en, busy, done;
    logic [SW-1:0] tx_data;
    logic [1:0]    state;
    logic [AW-1:0] sample_cnt;

    logic          start_c, adc_valid_c, tx_done_c;
    logic [AW-1:0] depth_sel_c;
    logic [SW-1:0] adc_data_c;
    logic          adc_en_c, tx_en_c, busy_c, done_c;
    logic [SW-1:0] tx_data_c;
    logic [1:0]    state_c;
    logic [AW-1:0] sample_cnt_c;

    capture_buffer #(.SAMPLE_W(SW), .DEPTH(DEPTH), .ADDR_W(AW), .CONTINUOUS(0)) dut (
        .clk(clk), .rst(rst), .start(start), .depth_sel(depth_sel),
        .adc_en(adc_en), .adc_valid(adc_valid), .adc_data(adc_data),
        .tx_en(tx_en), .tx_data(tx_data), .tx_done(tx_done),
        .busy(busy), .done(done), .state(state), .sample_cnt(sample_cnt)
    );

    capture_buffer #(.SAMPLE_W(SW), .DEPTH(DEPTH), .ADDR_W(AW), .CONTINUOUS(1)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .depth_sel(depth_sel_c),
        .adc_en(adc_en_c), .adc_valid(adc_valid_c), .adc_data(adc_data_c),
        .tx_en(tx_en_c), .tx_data(tx_data_c), .tx_done(tx_done_c),
        .busy(busy_c), .done(done_c), .state(state_c), .sample_cnt(sample_cnt_c)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit abort    = 1'b0;
    logic [SW-1:0] src_q[$];

    typedef struct {
        int ds;
        int lim;
        int mode;
        bit inject;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    function automatic int model_limit(input int ds);
        return (ds == 0 || ds > DEPTH) ? DEPTH : ds;
    endfunction

    task automatic fill_src(input int mode, input int n, input int base);
        src_q.delete();
        for (int i = 0; i < n; i++) begin
            if (mode == 0)      src_q.push_back(SW'($urandom));
            else if (mode == 1) src_q.push_back(SW'(i));
            else if (mode == 2) src_q.push_back(SW'(32'h111 * (i + 1)));
            else                src_q.push_back(SW'(base + i));
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; adc_valid = 1'b0; tx_done = 1'b0;
        start_c = 1'b0; adc_valid_c = 1'b0; tx_done_c = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        abort = 1'b0;
    endtask

    task automatic wait_adc_en();
        int k = 0;
        while (adc_en !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (adc_en !== 1'b1) begin
            chk("adc_en_timeout", 0, 1);
            abort = 1'b1;
        end
    endtask

    task automatic wait_tx_en();
        int k = 0;
        while (tx_en !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (tx_en !== 1'b1) begin
            chk("tx_en_timeout", 0, 1);
            abort = 1'b1;
        end
    endtask

    task automatic start_cycle(input int ds, input bit inject);
        if (inject) begin
            adc_valid = 1'b1; tx_done = 1'b1; adc_data = SW'($urandom);
            @(negedge clk);
            adc_valid = 1'b0; tx_done = 1'b0;
            chk("idle_ignore_state", int'(state), 0);
            chk("idle_ignore_cnt", int'(sample_cnt), 0);
            chk("idle_adc_en", int'(adc_en), 0);
        end
        depth_sel = AW'(ds);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        depth_sel = AW'($urandom);
        chk("arm_state", int'(state), 1);
        chk("arm_adc_en", int'(adc_en), 1);
        chk("arm_busy", int'(busy), 1);
        chk("arm_cnt", int'(sample_cnt), 0);
    endtask

    task automatic capture_phase(input int n, input bit inject);
        for (int i = 0; i < n; i++) begin
            if (abort) return;
            wait_adc_en();
            if (abort) return;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            chk("adc_en_hold", int'(adc_en), 1);
            adc_valid = 1'b1;
            adc_data  = src_q[i];
            @(negedge clk);
            adc_valid = 1'b0;
            adc_data  = SW'($urandom);
            chk("adc_en_gap", int'(adc_en), 0);
            if (i < n - 1) begin
                chk("cap_cnt", int'(sample_cnt), i + 1);
                chk("cap_state", int'(state), 1);
                if (inject) begin
                    adc_valid = 1'b1;
                    tx_done   = 1'b1;
                end
                @(negedge clk);
                adc_valid = 1'b0;
                tx_done   = 1'b0;
                chk("adc_en_back", int'(adc_en), 1);
                chk("cap_cnt_hold", int'(sample_cnt), i + 1);
            end else begin
                chk("to_tx_state", int'(state), 2);
                chk("tx_cnt_zero", int'(sample_cnt), 0);
                chk("tx_en_pre", int'(tx_en), 0);
                chk("tx_data_pre", int'(tx_data), int'(src_q[0]));
            end
        end
    endtask

    task automatic tx_phase(input int n, input int m, input bit inject);
        for (int i = 0; i < m; i++) begin
            if (abort) return;
            wait_tx_en();
            if (abort) return;
            chk("tx_data", int'(tx_data), int'(src_q[i]));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            chk("tx_data_stable", int'(tx_data), int'(src_q[i]));
            tx_done = 1'b1;
            if (inject) begin
                adc_valid = 1'b1;
                adc_data  = SW'($urandom);
            end
            @(negedge clk);
            tx_done   = 1'b0;
            adc_valid = 1'b0;
            chk("tx_en_gap", int'(tx_en), 0);
            chk("tx_cnt", int'(sample_cnt), i + 1);
            if (i < n - 1) begin
                chk("tx_data_next", int'(tx_data), int'(src_q[i + 1]));
                chk("tx_state", int'(state), 2);
                if (inject) tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
                chk("tx_en_back", int'(tx_en), 1);
                chk("tx_cnt_hold", int'(sample_cnt), i + 1);
            end else begin
                chk("done_state", int'(state), 3);
                chk("done_pulse", int'(done), 1);
                chk("done_busy", int'(busy), 0);
                @(negedge clk);
                chk("idle_state", int'(state), 0);
                chk("done_drop", int'(done), 0);
                chk("idle_cnt", int'(sample_cnt), 0);
            end
        end
    endtask

    task automatic run_cycle(input int ds, input int lim, input bit inject);
        if (abort) do_reset();
        start_cycle(ds, inject);
        capture_phase(lim, inject);
        tx_phase(lim, lim, inject);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        logic [SW-1:0] got[$];
        int dcount, nxt, lim, ds;
        bit prev_done, fin;

        tbl[0] = '{ds: 3,   lim: 3,   mode: 2, inject: 1'b0};
        tbl[1] = '{ds: 0,   lim: 100, mode: 1, inject: 1'b0};
        tbl[2] = '{ds: 3,   lim: 3,   mode: 2, inject: 1'b1};
        tbl[3] = '{ds: 127, lim: 100, mode: 0, inject: 1'b0};
        tbl[4] = '{ds: 1,   lim: 1,   mode: 0, inject: 1'b1};
        tbl[5] = '{ds: 100, lim: 100, mode: 0, inject: 1'b0};
        tbl[6] = '{ds: 101, lim: 100, mode: 1, inject: 1'b0};
        tbl[7] = '{ds: 2,   lim: 2,   mode: 0, inject: 1'b1};
        tbl[8] = '{ds: 99,  lim: 99,  mode: 0, inject: 1'b1};

        rst = 1'b0; start = 1'b0; adc_valid = 1'b0; tx_done = 1'b0;
        depth_sel = '0; adc_data = '0;
        start_c = 1'b0; adc_valid_c = 1'b0; tx_done_c = 1'b0;
        depth_sel_c = '0; adc_data_c = '0;
        repeat (3) @(negedge clk);
        chk("rst_state", int'(state), 0);
        chk("rst_adc_en", int'(adc_en), 0);
        chk("rst_tx_en", int'(tx_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_cnt", int'(sample_cnt), 0);
        rst = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 9; t++) begin
            fill_src(tbl[t].mode, tbl[t].lim, 0);
            run_cycle(tbl[t].ds, tbl[t].lim, tbl[t].inject);
        end

        for (int r = 0; r < 6; r++) begin
            ds  = (r < 3) ? $urandom_range(0, 12) : $urandom_range(0, 127);
            lim = model_limit(ds);
            fill_src(0, lim, 0);
            run_cycle(ds, lim, 1'($urandom_range(0, 1)));
        end

        if (abort) do_reset();
        fill_src(3, 5, 32'h800);
        start_cycle(5, 1'b0);
        capture_phase(5, 1'b0);
        tx_phase(5, 2, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_state", int'(state), 0);
        chk("mid_rst_adc_en", int'(adc_en), 0);
        chk("mid_rst_tx_en", int'(tx_en), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_tx_data", int'(tx_data), 0);
        chk("mid_rst_cnt", int'(sample_cnt), 0);
        rst = 1'b1;
        abort = 1'b0;
        @(negedge clk);
        fill_src(3, 3, 32'h400);
        run_cycle(3, 3, 1'b0);

        if (abort) do_reset();
        dcount = 0; nxt = 0; prev_done = 1'b0; fin = 1'b0;
        depth_sel_c = AW'(2);
        start_c = 1'b1;
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            @(negedge clk);
            if (prev_done) begin
                if (dcount == 1) begin
                    chk("cont_rearm_state", int'(state_c), 1);
                    chk("cont_rearm_adc_en", int'(adc_en_c), 1);
                    start_c = 1'b0;
                end else begin
                    chk("cont_idle_state", int'(state_c), 0);
                    fin = 1'b1;
                end
            end
            prev_done = done_c;
            if (done_c) dcount++;
            adc_valid_c = adc_en_c && !adc_valid_c;
            if (adc_valid_c) begin
                adc_data_c = SW'(32'h500 + nxt);
                nxt++;
            end
            tx_done_c = tx_en_c && !tx_done_c;
            if (tx_done_c) got.push_back(tx_data_c);
        end
        adc_valid_c = 1'b0;
        tx_done_c   = 1'b0;
        chk("cont_finished", int'(fin), 1);
        chk("cont_done_count", dcount, 2);
        chk("cont_n_sent", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++) begin
            chk("cont_data", int'(got[i]), 32'h500 + i);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
